simon_key_expander: RTL
=======================

Name: simon_key_expander

Overview:
- Parametrised, sequential SIMON key expander covering every SIMON n/mn variant: word width, key-word count, round count and z-sequence.
- Loads a master key over a valid/ready handshake, then streams round keys k[0]..k[ROUNDS-1] one word per accepted beat.
- Sits between the key-load interface and the round datapath. The round datapath consumes keys in order and may stall.

Parameters:
- WORD_W, 16, word size n in bits; legal values 16/24/32/48/64.
- KEY_WORDS, 4, key words m; legal values 2/3/4.
- ROUNDS, 32, total round keys T to emit; range KEY_WORDS+1..72.
- Z_SEL, 0, index 0..4 of the z constant sequence.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- key_valid  in  1  master key present.
- key_ready  out  1  block can accept a key.
- key_in  in  KEY_WORDS*WORD_W  master key; word j occupies bits [j*WORD_W +: WORD_W] and is k[j].
- rk_valid  out  1  round key valid.
- rk_ready  in  1  consumer accepts the round key.
- rk_data  out  WORD_W  current round key.
- rk_index  out  7  round index of rk_data.
- rk_last  out  1  high with the final round key.
- busy  out  1  schedule in progress.

Behaviour:
- Interface: one clock (clk). Reset is synchronous and active-low (rst_n): when rst_n=0 at a rising clk edge, the block resets regardless of any other input.
- Reset values: FSM=IDLE, key_ready=1, rk_valid=0, rk_data=0, rk_index=0, rk_last=0, busy=0, window registers=0.
- FSM has two states, IDLE and RUN.
- IDLE:
  - key_ready=1.
  - key_valid&key_ready loads window W[0..m-1]=k[0..m-1] and round counter r=0, then moves to RUN.
  - rk_valid goes high on the next cycle with rk_data=k[0]. Load-to-first-key latency is 1 cycle.
- RUN:
  - key_ready=0, busy=1, rk_valid=1, rk_data=W[0], rk_index=r, rk_last=(r==ROUNDS-1).
  - On rk_valid&rk_ready, W shifts down one word, W[m-1] receives the newly generated word, and r increments.
  - With rk_ready=0, all outputs and state hold unchanged.
- Generation of k[i+m] uses i=r, i.e. the word being retired:
  - t = ror(W[m-1],3).
  - If m==4: t ^= W[1].
  - t ^= ror(t,1).
  - new = ~W[0] ^ t ^ z[Z_SEL][i mod 62] ^ 3.
  - All arithmetic is modulo 2^WORD_W. The constant 3 and the z bit apply to bits [1:0] and bit 0 respectively.
- Generated words for i+m >= ROUNDS are computed but never presented.
- Final-key handshake: a handshake with rk_last=1 returns the FSM to IDLE. In that cycle rk_valid drops to 0, key_ready becomes 1, and rk_index/rk_last clear.
- A new key is never accepted in the same cycle as the final handshake. The minimum gap between schedules is 1 cycle.
- key_valid asserted during RUN is ignored; key_ready=0 throughout RUN.
- Reset asserted mid-schedule aborts it: the next cycle shows reset values and no further keys are emitted.
- r wraps only through the final-key handshake. Counting past ROUNDS-1 is impossible.

Optional Feature:
- Macro: SIMON_KS_REVERSE_EN.
- Defined:
  - Adds input key_dir (1 bit), sampled with the key handshake.
  - key_dir=0 gives the forward behaviour above.
  - key_dir=1 treats key_in word j as k[ROUNDS-m+j] and emits k[ROUNDS-1] down to k[0] for decryption.
  - rk_index counts down from ROUNDS-1; rk_last is asserted with index 0.
  - Backward step uses the window's top word as k[i+m]: k[i] = W_top ^ t(k[i+m-1], k[i+1]) ^ z[i] ^ ~0 ^ 3, with the same t as the forward step.
- Undefined: no key_dir port; forward only.

Decomposition:
- Package simon_pkg holds:
  - localparam array SIMON_Z[5] of 62-bit constants, bit i = z_j[i]. z0 string begins 11111010001001010110000111001101111101000100101011000011100110 (leftmost character = bit 0).
  - Function simon_ks_step(word args, m, zbit) shared by the forward and reverse paths.
  - Typedef ks_state_t {IDLE, RUN}.
- One sub-module, simon_ks_round_fn: the combinational word generator. The FSM and window stay in the top level.

Test Plan:
- SIMON32/64 forward, key words k0..k3 = 0x0100, 0x0908, 0x1110, 0x1918, rk_ready=1 -> rk_data sequence 0x0100, 0x0908, 0x1110, 0x1918, 0x71C3, 0xB649, ...; rk_last only at index 31; key_ready high the cycle after.
- Backpressure: same key, rk_ready toggled pseudo-randomly -> identical 32-word sequence, no drops or duplicates; outputs stable while stalled.
- Reset mid-run: rst_n=0 at index 10 -> reset values next cycle; reload succeeds; sequence restarts from 0x0100.
- Key during RUN: key_valid held high with a different key -> ignored; the original sequence completes.
- Parameter sweep WORD_W=64, KEY_WORDS=2, ROUNDS=68, Z_SEL=2 -> matches the SIMON128/128 reference model for all 68 words.
- SIMON_KS_REVERSE_EN: load the last 4 keys of a forward run with key_dir=1 -> emits the exact reverse sequence ending 0x0100 with rk_last at index 0.

Source files
------------

// File: rtl/simon_key_expander_pkg.sv
// Shared SIMON key-schedule definitions: z constant sequences, FSM state type and the
// width-generic key-schedule step used by both the forward and the reverse walk.
package simon_pkg;

    typedef enum logic {IDLE, RUN} ks_state_t;

    localparam int unsigned Z_LEN = 62;

    function automatic logic [61:0] rev62(input logic [61:0] x);
        logic [61:0] y;
        for (int i = 0; i < 62; i++) begin
            y[i] = x[61-i];
        end
        return y;
    endfunction

    // Literals are written as published (leftmost = z[0]), then bit-reversed so bit i = z[i].
    localparam logic [61:0] SIMON_Z [5] = '{
        rev62(62'b11111010001001010110000111001101111101000100101011000011100110),
        rev62(62'b10001110111110010011000010110101000111011111001001100001011010),
        rev62(62'b10101111011100000011010010011000101000010001111110010110110011),
        rev62(62'b11011011101011000110010111100000010010001010011100110100001111),
        rev62(62'b11010001111001101011011000100000010111000011001010010011101111)
    };

    function automatic logic [63:0] word_mask(input int unsigned word_w);
        logic [63:0] m;
        if (word_w >= 64) m = '1;
        else m = (64'd1 << word_w) - 64'd1;
        return m;
    endfunction

    function automatic logic [63:0] ror_w(input logic [63:0] x, input int unsigned s,
                                          input int unsigned word_w);
        return ((x >> s) | (x << (word_w - s))) & word_mask(word_w);
    endfunction

    // Result = ~w0 ^ t(wtop, w1) ^ z ^ 3. Forward: w0 is the retiring word; reverse: w0 is
    // k[i+m] and the result is k[i], since inverting w0 undoes the forward complement.
    function automatic logic [63:0] simon_ks_step(input logic [63:0] w0,
                                                  input logic [63:0] wtop,
                                                  input logic [63:0] w1,
                                                  input int unsigned word_w,
                                                  input int unsigned m,
                                                  input logic zbit);
        logic [63:0] t;
        t = ror_w(wtop, 3, word_w);
        if (m == 4) t = t ^ w1;
        t = t ^ ror_w(t, 1, word_w);
        return (~w0 ^ t ^ 64'd3 ^ {63'd0, zbit}) & word_mask(word_w);
    endfunction

endpackage

// File: rtl/simon_key_expander_if.sv
// Key-load and round-key stream bundle for simon_key_expander; key_dir exists only when
// SIMON_KS_REVERSE_EN is defined.
interface simon_key_expander_if #(
    parameter int unsigned WORD_W    = 16,
    parameter int unsigned KEY_WORDS = 4
);
    logic                          key_valid;
    logic                          key_ready;
    logic [KEY_WORDS*WORD_W-1:0]   key_in;
`ifdef SIMON_KS_REVERSE_EN
    logic                          key_dir;
`endif
    logic                          rk_valid;
    logic                          rk_ready;
    logic [WORD_W-1:0]             rk_data;
    logic [6:0]                    rk_index;
    logic                          rk_last;
    logic                          busy;

    modport master (
`ifdef SIMON_KS_REVERSE_EN
        output key_dir,
`endif
        output key_valid, key_in, rk_ready,
        input  key_ready, rk_valid, rk_data, rk_index, rk_last, busy
    );

    modport slave (
`ifdef SIMON_KS_REVERSE_EN
        input  key_dir,
`endif
        input  key_valid, key_in, rk_ready,
        output key_ready, rk_valid, rk_data, rk_index, rk_last, busy
    );
endinterface

// File: rtl/simon_key_expander_round_fn.sv
// Combinational SIMON key-schedule word generator, one step forward or backward depending
// on which window words the caller presents.
module simon_ks_round_fn
    import simon_pkg::*;
#(
    parameter int unsigned WORD_W    = 16,
    parameter int unsigned KEY_WORDS = 4
) (
    input  logic [WORD_W-1:0] w0_i,
    input  logic [WORD_W-1:0] wtop_i,
    input  logic [WORD_W-1:0] w1_i,
    input  logic              zbit_i,
    output logic [WORD_W-1:0] word_o
);
    assign word_o = WORD_W'(simon_ks_step(64'(w0_i), 64'(wtop_i), 64'(w1_i),
                                          WORD_W, KEY_WORDS, zbit_i));
endmodule

// File: rtl/simon_key_expander.sv
// Sequential SIMON key expander: loads an m-word master key, streams T round keys.
// Optional SIMON_KS_REVERSE_EN adds key_dir for a k[T-1]..k[0] decryption walk.
module simon_key_expander
    import simon_pkg::*;
#(
    parameter int unsigned WORD_W    = 16,
    parameter int unsigned KEY_WORDS = 4,
    parameter int unsigned ROUNDS    = 32,
    parameter int unsigned Z_SEL     = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    simon_key_expander_if.slave  bus
);
    localparam logic [61:0] ZSeq    = SIMON_Z[Z_SEL];
    localparam logic [6:0]  LastFwd = 7'(ROUNDS - 1);
    localparam logic [6:0]  KwIdx   = 7'(KEY_WORDS);

    ks_state_t         state_q, state_d;
    logic [WORD_W-1:0] win_q [KEY_WORDS];
    logic [WORD_W-1:0] win_d [KEY_WORDS];
    logic [6:0]        r_q, r_d;
    logic              dir_q, dir_d;
    logic              load_dir;

    logic              run;
    logic              last;
    logic              hs;
    logic [6:0]        z_idx;
    logic              zbit;
    logic [WORD_W-1:0] fn_w0, fn_wtop, fn_w1, fn_word;

`ifdef SIMON_KS_REVERSE_EN
    assign load_dir = bus.key_dir;
`else
    assign load_dir = 1'b0;
`endif

    assign run  = (state_q == RUN);
    assign last = run && (r_q == (dir_q ? 7'd0 : LastFwd));
    assign hs   = run && bus.rk_ready;

    // Reverse generates k[r-m]; indices below zero are never presented, so any z bit will do.
    assign z_idx = dir_q ? ((r_q >= KwIdx) ? r_q - KwIdx : 7'd0) : r_q;
    assign zbit  = ZSeq[6'((z_idx >= 7'(Z_LEN)) ? z_idx - 7'(Z_LEN) : z_idx)];

    assign fn_w0   = dir_q ? win_q[KEY_WORDS-1] : win_q[0];
    assign fn_wtop = dir_q ? win_q[KEY_WORDS-2] : win_q[KEY_WORDS-1];
    assign fn_w1   = dir_q ? win_q[0]           : win_q[1];

    simon_ks_round_fn #(
        .WORD_W    (WORD_W),
        .KEY_WORDS (KEY_WORDS)
    ) u_round_fn (
        .w0_i   (fn_w0),
        .wtop_i (fn_wtop),
        .w1_i   (fn_w1),
        .zbit_i (zbit),
        .word_o (fn_word)
    );

    assign bus.key_ready = (state_q == IDLE);
    assign bus.busy      = run;
    assign bus.rk_valid  = run;
    assign bus.rk_data   = run ? (dir_q ? win_q[KEY_WORDS-1] : win_q[0]) : '0;
    assign bus.rk_index  = r_q;
    assign bus.rk_last   = last;

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        r_d     = r_q;
        dir_d   = dir_q;
        unique case (state_q)
            IDLE: begin
                if (bus.key_valid) begin
                    for (int j = 0; j < KEY_WORDS; j++) begin
                        win_d[j] = bus.key_in[j*WORD_W +: WORD_W];
                    end
                    dir_d   = load_dir;
                    r_d     = load_dir ? LastFwd : 7'd0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (hs) begin
                    if (dir_q) begin
                        for (int j = KEY_WORDS - 1; j > 0; j--) win_d[j] = win_q[j-1];
                        win_d[0] = fn_word;
                    end else begin
                        for (int j = 0; j < KEY_WORDS - 1; j++) win_d[j] = win_q[j+1];
                        win_d[KEY_WORDS-1] = fn_word;
                    end
                    if (last) begin
                        r_d     = 7'd0;
                        state_d = IDLE;
                    end else begin
                        r_d = dir_q ? r_q - 7'd1 : r_q + 7'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            r_q     <= '0;
            dir_q   <= 1'b0;
            for (int j = 0; j < KEY_WORDS; j++) win_q[j] <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            dir_q   <= dir_d;
            for (int j = 0; j < KEY_WORDS; j++) win_q[j] <= win_d[j];
        end
    end
endmodule
